conv_result_writer: RTL and testbench
=====================================

Name: conv_result_writer

Overview:
- Consumer end of the conv result stream: captures each 32-bit signed convolution result, applies ReLU and requantisation to 8 bits, and stores it row-major into an internal output feature-map RAM.
- The RAM is sized for one valid-padding frame of (H-2)x(W-2) results.
- Pulses done when a full frame is stored.
- Exposes a registered read port for the next layer (pooling / dense).

Parameters:
- H, 28, input image height; output map has H-2 rows
- W, 28, input image width; output map has W-2 columns
- SHIFT, 8, arithmetic right-shift applied to the result before saturation
- OUT_W, 8, stored word width; saturation ceiling is 2^OUT_W-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: clear pointer/counters, begin accepting a frame
- in_valid  in  1  in_data holds a conv result this cycle
- in_data  in  32  signed conv result
- in_ready  out  1  writer accepts a beat this cycle
- rd_addr  in  10  feature-map read address, row-major
- rd_data  out  OUT_W  registered read data
- busy  out  1  frame capture in progress
- done  out  1  one-cycle pulse: last result of the frame committed to RAM
- count  out  10  beats accepted in the current/last frame
- drop_err  out  1  sticky: in_valid seen while in_ready low

Behaviour:
- N = (H-2)*(W-2); default 676. N must be at most 1024.
- Reset values: state IDLE, in_ready 0, busy 0, done 0, count 0, drop_err 0, rd_data 0. Write pointer and pipeline valid are 0. RAM contents are not cleared.
- States:
  - IDLE: in_ready=0, busy=0. start -> ACCEPT; count, pointer and drop_err clear at that edge.
  - ACCEPT: in_ready=1, busy=1. A beat is accepted at an edge where in_valid=1.
  - When the accepted beat is number N (count reaches N), the state -> FLUSH at that same edge.
  - FLUSH: in_ready=0, busy=1. At the next edge: the staged write commits, done registers 1, state -> IDLE.
- Quantisation, per accepted beat:
  - d<0 -> 0.
  - else s = d>>>SHIFT; q = (s > 2^OUT_W-1) ? 2^OUT_W-1 : s[OUT_W-1:0].
  - Computed combinationally and registered into a one-entry stage (data, address, valid) at the accept edge.
- Write timing: a beat accepted at edge k is written to RAM[ptr] at edge k+1. ptr increments at the accept edge.
- Back-to-back beats sustain 1 per cycle.
- done:
  - Last beat accepted at edge k -> done high for exactly the cycle following edge k+1.
  - busy is low in that same cycle.
- count increments per accepted beat. It holds its value after done until the next start.
- drop_err sets at any edge with in_valid=1 and in_ready=0. It clears only on start or rst.
- Read port:
  - rd_data <= RAM[rd_addr] every edge, 1-cycle latency, in any state.
  - rd_addr >= N returns 0.
  - Same-address read and write at one edge returns the old data.
- start while ACCEPT or FLUSH: restart. The pending staged write is discarded (valid cleared), pointer and count -> 0, state ACCEPT, no done pulse.
- start and in_valid at the same edge in IDLE: start wins, the beat is not accepted, drop_err stays 0.
- rst mid-frame: all of the above return to reset values at the edge. No pending write commits.

Test Plan:
- Quantisation: SHIFT=8; start, then beats 1000, -5, 70000, 255, 256 -> RAM[0..4] = 3, 0, 255, 0, 1; read back via rd_addr with rd_data valid one cycle later.
- Full frame: start, then 676 back-to-back beats d=i<<8 (i=0..675) -> done one cycle after the last write. count=676, busy=0, RAM[i] = min(i,255), rd_addr=700 -> rd_data=0.
- Throttled stream: in_valid asserted every third cycle for 676 beats -> same RAM contents, exactly one done pulse, drop_err=0.
- Restart: after 100 beats, pulse start, then send 676 beats of 0x200 -> count=676, all RAM=2, single done pulse.
- Protocol error: in_valid=1 in IDLE with start=0 -> drop_err=1, count unchanged. The next start clears drop_err.
- Reset mid-frame: rst at beat 300 -> next cycle in_ready=0, busy=0, count=0, done never pulses. A new start and a full frame then complete normally.

Source files
------------

// File: rtl/conv_result_writer_if.sv
// Conv result stream: producer drives in_valid/in_data, the writer answers in_ready.
// No storage and no latency; this is only a bundle of wires.
// A beat transfers on an edge where in_valid and in_ready are both high.
interface conv_result_writer_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/conv_result_writer.sv
// Captures a frame of conv results, applies ReLU + requantisation to OUT_W bits, and stores them row-major.
// Latency: a beat accepted at edge k lands in RAM at edge k+1; the read port has 1-cycle latency.
// Backpressure: in_ready is high only while accepting a frame; a beat offered while it is low sets drop_err.
module conv_result_writer #(
  parameter int H     = 28,
  parameter int W     = 28,
  parameter int SHIFT = 8,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  conv_result_writer_if.slave   strm,
  input  logic [9:0]            rd_addr,
  output logic [OUT_W-1:0]      rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [9:0]            count,
  output logic                  drop_err
);

  localparam int                N      = (H - 2) * (W - 2);
  localparam logic [9:0]        LAST   = 10'(N - 1);
  localparam logic [10:0]       N_L    = 11'(N);
  localparam logic signed [31:0] QMAX  = 32'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, FLUSH} state_t;

  state_t             state;
  logic [9:0]         ptr;
  logic               stg_vld;
  logic [9:0]         stg_addr;
  logic [OUT_W-1:0]   stg_dat;
  logic signed [31:0] shifted;
  logic [OUT_W-1:0]   q;
  logic [OUT_W-1:0]   ram [0:N-1];

  // ReLU, arithmetic shift, then clamp to the top of the OUT_W range
  always_comb begin
    shifted = $signed(strm.in_data) >>> SHIFT;
    q       = '0;
    if (strm.in_data[31])
      q = '0;
    else if (shifted > QMAX)
      q = QMAX[OUT_W-1:0];
    else
      q = shifted[OUT_W-1:0];
  end

  // Frame control FSM with registered handshake/status outputs and the one-entry write stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      strm.in_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      count         <= '0;
      drop_err      <= 1'b0;
      ptr           <= '0;
      stg_vld       <= 1'b0;
      stg_addr      <= '0;
      stg_dat       <= '0;
    end else begin
      done    <= 1'b0;
      stg_vld <= 1'b0;
      if (strm.in_valid && !strm.in_ready)
        drop_err <= 1'b1;
      if (start) begin
        // Restart from any state; a beat offered this edge is not taken
        state         <= ACCEPT;
        strm.in_ready <= 1'b1;
        busy          <= 1'b1;
        count         <= '0;
        ptr           <= '0;
        drop_err      <= 1'b0;
      end else begin
        case (state)
          ACCEPT: begin
            if (strm.in_valid) begin
              stg_vld  <= 1'b1;
              stg_addr <= ptr;
              stg_dat  <= q;
              ptr      <= ptr + 10'd1;
              count    <= count + 10'd1;
              if (count == LAST) begin
                state         <= FLUSH;
                strm.in_ready <= 1'b0;
              end
            end
          end
          FLUSH: begin
            // The final staged write commits at this edge
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Commit the staged beat; reset and restart both discard it
  always_ff @(posedge clk) begin
    if (stg_vld && !rst && !start)
      ram[stg_addr] <= stg_dat;
  end

  // Registered read port; out-of-frame addresses read as zero, same-edge writes are not forwarded
  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if ({1'b0, rd_addr} < N_L)
      rd_data <= ram[rd_addr];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: one task per scenario, inline comparisons.
// Inputs are driven #1 after the rising edge and outputs are sampled at the same point.
// Done pulses are counted on the falling edge by a small monitor.
module tb_conv_result_writer;

  localparam int N = 676;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [9:0] count;
  logic       drop_err;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;

  conv_result_writer_if strm ();

  conv_result_writer #(.H(28), .W(28), .SHIFT(8), .OUT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .strm     (strm.slave),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .drop_err (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (strm.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", strm.in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (count !== 10'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop_err got=%b want=0", drop_err); end
    total++; if (rd_data !== 8'd0) begin bad++; $display("FAIL reset_rd_data got=%0d want=0", rd_data); end
  endtask

  task automatic test_quant();
    int qin [5]  = '{1000, -5, 70000, 255, 256};
    int qexp [5] = '{3, 0, 255, 0, 1};
    pulse_start();
    total++; if (strm.in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL quant_accept_state got=%b%b want=11", strm.in_ready, busy); end
    for (int i = 0; i < 5; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = 32'(qin[i]);
      tick();
    end
    strm.in_valid = 1'b0;
    total++; if (count !== 10'd5) begin bad++; $display("FAIL quant_count got=%0d want=5", count); end
    for (int i = 0; i < 5; i++) begin
      rd_addr = 10'(i);
      tick();
      total++; if (rd_data !== 8'(qexp[i])) begin bad++; $display("FAIL quant_ram[%0d] got=%0d want=%0d", i, rd_data, qexp[i]); end
    end
  endtask

  task automatic test_full_frame();
    pulse_start();
    done_pulses = 0;
    for (int i = 0; i < N; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = 32'(i) << 8;
      tick();
    end
    strm.in_valid = 1'b0;
    total++; if (strm.in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL full_flush got ready=%b busy=%b done=%b want 0 1 0", strm.in_ready, busy, done); end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL full_done got done=%b busy=%b want 1 0", done, busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL full_done_width got=%b want=0", done); end
    total++; if (count !== 10'd676) begin bad++; $display("FAIL full_count got=%0d want=676", count); end
    for (int i = 0; i < N; i++) begin
      rd_addr = 10'(i);
      tick();
      total++; if (rd_data !== 8'((i > 255) ? 255 : i)) begin bad++; $display("FAIL full_ram[%0d] got=%0d want=%0d", i, rd_data, (i > 255) ? 255 : i); end
    end
    rd_addr = 10'd700;
    tick();
    total++; if (rd_data !== 8'd0) begin bad++; $display("FAIL full_oob_read got=%0d want=0", rd_data); end
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", done_pulses); end
  endtask

  task automatic test_restart();
    pulse_start();
    done_pulses = 0;
    for (int i = 0; i < 100; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = 32'h5000;
      tick();
    end
    strm.in_valid = 1'b0;
    total++; if (count !== 10'd100) begin bad++; $display("FAIL restart_mid_count got=%0d want=100", count); end
    pulse_start();
    total++; if (count !== 10'd0 || busy !== 1'b1) begin bad++; $display("FAIL restart_clear got count=%0d busy=%b want 0 1", count, busy); end
    for (int i = 0; i < N; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = 32'h200;
      tick();
    end
    strm.in_valid = 1'b0;
    tick();
    tick();
    total++; if (count !== 10'd676) begin bad++; $display("FAIL restart_count got=%0d want=676", count); end
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL restart_done_pulses got=%0d want=1", done_pulses); end
    for (int i = 0; i < N; i++) begin
      rd_addr = 10'(i);
      tick();
      total++; if (rd_data !== 8'd2) begin bad++; $display("FAIL restart_ram[%0d] got=%0d want=2", i, rd_data); end
    end
  endtask

  task automatic test_throttle();
    pulse_start();
    done_pulses = 0;
    for (int i = 0; i < N; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = 32'(i) << 8;
      tick();
      strm.in_valid = 1'b0;
      tick();
      tick();
    end
    tick();
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL throttle_done_pulses got=%0d want=1", done_pulses); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL throttle_drop_err got=%b want=0", drop_err); end
    total++; if (count !== 10'd676) begin bad++; $display("FAIL throttle_count got=%0d want=676", count); end
    for (int i = 0; i < N; i++) begin
      rd_addr = 10'(i);
      tick();
      total++; if (rd_data !== 8'((i > 255) ? 255 : i)) begin bad++; $display("FAIL throttle_ram[%0d] got=%0d want=%0d", i, rd_data, (i > 255) ? 255 : i); end
    end
  endtask

  task automatic test_protocol();
    strm.in_valid = 1'b1;
    strm.in_data  = 32'h1234;
    tick();
    strm.in_valid = 1'b0;
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL proto_drop_set got=%b want=1", drop_err); end
    total++; if (count !== 10'd676) begin bad++; $display("FAIL proto_count_hold got=%0d want=676", count); end
    tick();
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL proto_drop_sticky got=%b want=1", drop_err); end
    // start together with a beat in IDLE: start wins, beat ignored, no drop flagged
    start = 1'b1;
    strm.in_valid = 1'b1;
    tick();
    start = 1'b0;
    strm.in_valid = 1'b0;
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL proto_drop_clear got=%b want=0", drop_err); end
    total++; if (count !== 10'd0) begin bad++; $display("FAIL proto_start_wins got=%0d want=0", count); end
  endtask

  task automatic test_reset_midframe();
    pulse_start();
    done_pulses = 0;
    for (int i = 0; i < 300; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = 32'h1000;
      tick();
    end
    strm.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (strm.in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_state got ready=%b busy=%b want 0 0", strm.in_ready, busy); end
    total++; if (count !== 10'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", count); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (done_pulses !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", done_pulses); end
    rd_addr = 10'd298;
    tick();
    total++; if (rd_data !== 8'd16) begin bad++; $display("FAIL midrst_ram[298] got=%0d want=16", rd_data); end
    rd_addr = 10'd299;
    tick();
    total++; if (rd_data !== 8'd255) begin bad++; $display("FAIL midrst_pending_write got=%0d want=255", rd_data); end
    pulse_start();
    for (int i = 0; i < N; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = 32'(i % 7) << 8;
      tick();
    end
    strm.in_valid = 1'b0;
    tick();
    tick();
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL midrst_frame_done got=%0d want=1", done_pulses); end
    total++; if (count !== 10'd676 || busy !== 1'b0) begin bad++; $display("FAIL midrst_frame_end got count=%0d busy=%b want 676 0", count, busy); end
    for (int i = 0; i < N; i++) begin
      rd_addr = 10'(i);
      tick();
      total++; if (rd_data !== 8'(i % 7)) begin bad++; $display("FAIL midrst_ram[%0d] got=%0d want=%0d", i, rd_data, i % 7); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    rd_addr       = '0;
    strm.in_valid = 1'b0;
    strm.in_data  = '0;
    test_reset();
    test_quant();
    test_full_frame();
    test_restart();
    test_throttle();
    test_protocol();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
